// File: rtl/regfile_dump.sv
// regfile_dump: sequential read-out of a 32 x N-bit register file onto a
// valid/ready stream, one index/data beat per register.
//
// Optional feature macro: REGDUMP_SKIP_XZR_EN
//   defined   -> X31 (XZR) is skipped, beats idx 0..30
//   undefined -> all 32 registers are dumped, beats idx 0..31
//
// Ports:
//   clk        clock, rising edge
//   reset      synchronous active-high reset
//   start      dump request, accepted only in IDLE
//   ra         read address to the register file read port
//   rd         combinational read data for ra
//   busy       dump in progress (READ/SEND)
//   done       one-cycle pulse after the last beat handshakes
//   out_valid  beat available
//   out_ready  consumer accepts beat
//   out_idx    register number of the current beat
//   out_data   register contents of the current beat
module regfile_dump #(
  parameter int unsigned N = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [4:0]       ra,
  input  logic [N-1:0]     rd,
  output logic             busy,
  output logic             done,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0]       out_idx,
  output logic [N-1:0]     out_data
);

  localparam int unsigned IW = 5;
`ifdef REGDUMP_SKIP_XZR_EN
  localparam logic [IW-1:0] LAST = IW'(30);
`else
  localparam logic [IW-1:0] LAST = IW'(31);
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    FIN  = 2'd3
  } state_t;

  state_t          state, state_n;
  logic [IW-1:0]   idx, idx_n;
  logic [IW-1:0]   ra_n;
  logic            busy_n, done_n, out_valid_n;
  logic [IW-1:0]   out_idx_n;
  logic [N-1:0]    out_data_n;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      ra        <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_data  <= '0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      ra        <= ra_n;
      busy      <= busy_n;
      done      <= done_n;
      out_valid <= out_valid_n;
      out_idx   <= out_idx_n;
      out_data  <= out_data_n;
    end
  end

  // Next state and next register values; ra is loaded one cycle ahead so it
  // equals idx throughout READ and is 0 in IDLE/FIN.
  always_comb begin
    state_n     = state;
    idx_n       = idx;
    ra_n        = ra;
    busy_n      = busy;
    done_n      = 1'b0;
    out_valid_n = out_valid;
    out_idx_n   = out_idx;
    out_data_n  = out_data;

    case (state)
      IDLE: begin
        ra_n = '0;
        if (start) begin
          state_n = READ;
          idx_n   = '0;
          busy_n  = 1'b1;
        end
      end

      READ: begin
        // rd is only ever captured here, so the stream is fully registered
        out_data_n  = rd;
        out_idx_n   = idx;
        out_valid_n = 1'b1;
        state_n     = SEND;
      end

      SEND: begin
        if (out_valid && out_ready) begin
          out_valid_n = 1'b0;
          if (idx == LAST) begin
            state_n = FIN;
            busy_n  = 1'b0;
            done_n  = 1'b1;
            ra_n    = '0;
          end else begin
            idx_n   = IW'(idx + 1'b1);
            ra_n    = IW'(idx + 1'b1);
            state_n = READ;
          end
        end
      end

      FIN: begin
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_regfile_dump.sv
// tb_regfile_dump: directed self-checking bench for regfile_dump with a
// behavioural 32 x 64 register file driving rd combinationally from ra.
module tb_regfile_dump;

`ifdef REGDUMP_SKIP_XZR_EN
  localparam int LAST = 30;
`else
  localparam int LAST = 31;
`endif
  localparam int NBEATS = LAST + 1;

  logic        clk;
  logic        reset;
  logic        start;
  logic [4:0]  ra;
  logic [63:0] rd;
  logic        busy;
  logic        done;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_idx;
  logic [63:0] out_data;

  logic [63:0] regs [32];
  assign rd = regs[ra];

  regfile_dump #(.N(64)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .ra        (ra),
    .rd        (rd),
    .busy      (busy),
    .done      (done),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_data  (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Results of one collected dump
  logic [4:0]  b_idx  [64];
  logic [63:0] b_data [64];
  int nbeats, busy_cyc, done_cnt, done_at, last_hs, stall_hold_ok;

  task automatic init_regs();
    for (int i = 0; i < 31; i++) regs[i] = 64'(i);
    regs[31] = 64'd0;
  endtask

  // Pulse start, then run the stream to completion, recording beats.
  // stall_idx/stall_len: hold out_ready low for stall_len cycles on that beat.
  // repulse: pulse start during beat 10 and in the done cycle.
  task automatic collect(input int stall_idx, input int stall_len,
                         input int stall_data, input bit repulse);
    int  stall_cnt;
    bit  pulsed10;
    nbeats = 0; busy_cyc = 0; done_cnt = 0; done_at = -1; last_hs = -1;
    stall_hold_ok = 0; stall_cnt = 0; pulsed10 = 1'b0;
    @(negedge clk);
    start = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (busy) busy_cyc++;
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = cyc;
      end
      start = 1'b0;
      if (repulse && out_valid && out_idx == 5'd10 && !pulsed10) begin
        start = 1'b1;
        pulsed10 = 1'b1;
      end
      if (repulse && done) start = 1'b1;
      if (out_valid && int'(out_idx) == stall_idx && stall_cnt < stall_len) begin
        out_ready = 1'b0;
        stall_cnt++;
        if (int'(out_idx) == stall_idx && out_data == 64'(stall_data)) stall_hold_ok++;
      end else begin
        out_ready = 1'b1;
      end
      if (out_valid && out_ready) begin
        if (nbeats < 64) begin
          b_idx[nbeats]  = out_idx;
          b_data[nbeats] = out_data;
        end
        nbeats++;
        last_hs = cyc;
      end
      if (done_at >= 0 && cyc >= done_at + 4) break;
      @(negedge clk);
    end
    start = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({ra, busy, done, out_valid, out_idx} !== 13'd0 || out_data !== 64'd0) begin
      errors++;
      $display("FAIL reset_values: ra=%0d busy=%0b done=%0b valid=%0b idx=%0d data=%h, required all 0",
               ra, busy, done, out_valid, out_idx, out_data);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_quiet: busy=%0b valid=%0b, required 0/0", busy, out_valid);
    end
  endtask

  // Check a collected dump against Xk=k (X31=0), with optional override of X5.
  task automatic check_dump(input string name, input bit x5_mod, input int exp_busy);
    logic [63:0] exp_d;
    checks++;
    if (nbeats !== NBEATS) begin
      errors++;
      $display("FAIL %s_beats: got %0d beats, required %0d", name, nbeats, NBEATS);
    end
    for (int k = 0; k < NBEATS && k < nbeats; k++) begin
      exp_d = (k == 31) ? 64'd0 : 64'(k);
      if (x5_mod && k == 5) exp_d = 64'hDEADBEEF_CAFEF00D;
      checks++;
      if (b_idx[k] !== 5'(k) || b_data[k] !== exp_d) begin
        errors++;
        $display("FAIL %s_beat%0d: got idx=%0d data=%h, required idx=%0d data=%h",
                 name, k, b_idx[k], b_data[k], k, exp_d);
      end
    end
    checks++;
    if (done_cnt !== 1) begin
      errors++;
      $display("FAIL %s_done_count: got %0d, required 1", name, done_cnt);
    end
    checks++;
    if (done_at < 0 || done_at !== last_hs + 1) begin
      errors++;
      $display("FAIL %s_done_timing: done at %0d last handshake %0d, required done = handshake+1",
               name, done_at, last_hs);
    end
    checks++;
    if (busy_cyc !== exp_busy || done_at !== exp_busy) begin
      errors++;
      $display("FAIL %s_latency: busy cycles %0d done at %0d, required %0d",
               name, busy_cyc, done_at, exp_busy);
    end
  endtask

  task automatic test_full_dump();
    init_regs();
    collect(-1, 0, 0, 1'b0);
    check_dump("full", 1'b0, 2 * NBEATS);
  endtask

  task automatic test_backpressure();
    init_regs();
    collect(3, 5, 3, 1'b0);
    checks++;
    if (stall_hold_ok !== 5) begin
      errors++;
      $display("FAIL bp_hold: stable cycles %0d, required 5", stall_hold_ok);
    end
    check_dump("bp", 1'b0, 2 * NBEATS + 5);
  endtask

  task automatic test_data_pattern();
    init_regs();
    regs[5] = 64'hDEADBEEF_CAFEF00D;
    collect(-1, 0, 0, 1'b0);
    check_dump("x5", 1'b1, 2 * NBEATS);
    init_regs();
  endtask

  task automatic test_restart_ignored();
    init_regs();
    collect(-1, 0, 0, 1'b1);
    check_dump("repulse", 1'b0, 2 * NBEATS);
  endtask

  task automatic test_reset_mid_dump();
    bit found;
    int extra;
    init_regs();
    found = 1'b0;
    @(negedge clk);
    start = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      if (out_valid && out_idx == 5'd7) begin
        out_ready = 1'b0;
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL rst_mid_reach: beat 7 not seen within 100 cycles, required seen");
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || out_data !== 64'd0 || done !== 1'b0 ||
        ra !== 5'd0 || out_idx !== 5'd0) begin
      errors++;
      $display("FAIL rst_mid_outputs: busy=%0b valid=%0b data=%h done=%0b ra=%0d idx=%0d, required all 0",
               busy, out_valid, out_data, done, ra, out_idx);
    end
    extra = 0;
    repeat (10) begin
      @(negedge clk);
      if (done || busy || out_valid) extra++;
    end
    checks++;
    if (extra !== 0) begin
      errors++;
      $display("FAIL rst_mid_quiet: %0d active cycles after reset, required 0", extra);
    end
    collect(-1, 0, 0, 1'b0);
    checks++;
    if (nbeats < 1 || b_idx[0] !== 5'd0) begin
      errors++;
      $display("FAIL rst_mid_restart_idx: beats %0d first idx %0d, required first idx 0",
               nbeats, b_idx[0]);
    end
    check_dump("restart", 1'b0, 2 * NBEATS);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    out_ready = 1'b0;
    init_regs();
    test_reset();
    test_full_dump();
    test_backpressure();
    test_data_pattern();
    test_restart_ignored();
    test_reset_mid_dump();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_dump.md
# regfile_dump

Sequential read-out engine for the processor's 32 x 64-bit register file. On a start pulse it drives the register file's read-address port through X0..X31, captures each read value, and presents it as an index/data beat on a valid/ready stream. The stream feeds the testbench scoreboard or the debug UART. It sits beside the datapath, shares read port 1 of the register file (muxed in by the core's debug-halt logic), and never writes the register file.

## Interface
- N, 64, data width of one register
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; sampled on rising edge of clk
- start  in  1  dump request; accepted only in IDLE
- ra  out  5  read address driven to the register file read port
- rd  in  N  combinational read data returned by the register file for `ra`
- busy  out  1  high from the cycle after `start` is accepted until `done` is asserted
- done  out  1  one-cycle pulse after the last beat handshakes
- out_valid  out  1  beat available
- out_ready  in  1  consumer accepts beat
- out_idx  out  5  register number of the current beat
- out_data  out  N  register contents of the current beat

## Operation
- FSM states: IDLE, READ, SEND, FIN.
- IDLE: `ra`=0. `start`=1 -> READ, `busy`=1, index=0.
- READ: `ra`=index. End of cycle: `out_data`<=`rd`, `out_idx`<=index, `out_valid`<=1 -> SEND.
- SEND: hold `out_valid`, `out_idx`, `out_data` stable while `out_ready`=0.
  - `out_valid`&&`out_ready` with index<LAST -> index+1, `out_valid`<=0 -> READ.
  - `out_valid`&&`out_ready` with index==LAST -> `out_valid`<=0 -> FIN.
- FIN: `done`=1, `busy`=0 for exactly one cycle -> IDLE.
- LAST = 31, or 30 under REGDUMP_SKIP_XZR_EN.
- `start` outside IDLE is ignored. No queued restart.
- Index is 5 bits with no wrap. The LAST compare terminates the scan before any wrap.
- Register data is not interpreted. X31 is dumped as whatever the register file returns for address 31, normally 0.

## Timing
- Reset values: `ra`=0, `busy`=0, `done`=0, `out_valid`=0, `out_idx`=0, `out_data`=0. State = IDLE.
- Reset mid-dump: the next cycle is IDLE with all outputs at reset values. The partial dump is abandoned and no `done` is pulsed.
- `start` at edge t -> READ during cycle t+1 -> `out_valid`=1 from edge t+2.
- With `out_ready` tied high, each register takes 2 cycles, so a full dump is 64 cycles from the first READ to FIN.
- `done` asserts the cycle after the last handshake.
- `start` in the FIN cycle is ignored. A new `start` is accepted in the following IDLE cycle at the earliest.
- The `rd` path is combinational from `ra`. It is registered only into `out_data`, so no combinational path runs from `rd` to the stream outputs.
- `out_ready` may toggle arbitrarily. A beat is transferred only on an edge where `out_valid` and `out_ready` are both 1.

## Configuration
- Macro: REGDUMP_SKIP_XZR_EN.
- Defined: X31/XZR is not dumped. LAST=30, so a dump is 31 beats (idx 0..30).
- Undefined: all 32 registers are dumped. LAST=31, so a dump is 32 beats (idx 0..31).

## Test plan
- Register file initialised with Xi=i (X31=0), `out_ready`=1, `start` pulse. Required response:
  - 32 beats with idx=k, data=k for k=0..30, then idx=31 data=0.
  - `done` one cycle after the last beat; 64 cycles from READ to FIN.
- Backpressure: `out_ready` low for 5 cycles on beat 3. Required response:
  - `out_idx`=3 and `out_data`=3 stay stable for those 5 cycles.
  - No beats are lost or duplicated.
  - Total dump latency grows by exactly 5 cycles.
- Write X5=64'hDEADBEEF_CAFEF00D before `start`. Required response: beat 5 carries 64'hDEADBEEF_CAFEF00D and all other beats are unchanged.
- `start` re-pulsed during beat 10 and again in the FIN cycle. Required response:
  - Both pulses are ignored.
  - Exactly one dump and one `done` pulse are produced.
- Reset asserted while in SEND on beat 7. Required response:
  - Next cycle `busy`=0, `out_valid`=0, `out_data`=0, no `done`.
  - A later `start` restarts the dump at idx 0.
- REGDUMP_SKIP_XZR_EN defined, same stimulus as the first test. Required response: 31 beats ending at idx 30, with `done` following.
